// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run controller and the instruction memory.
package cpu_ctrl_pkg;

  localparam int DEF_ADDR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HALT = 3'd2,
    ST_RUN  = 3'd3,
    ST_STEP = 3'd4
  } state_e;

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: streams a program into instruction memory, then sequences
// free run / single step / halt of the CPU through cpu_rst and cpu_en.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  input  logic              cmd_run,
  input  logic              cmd_step,
  input  logic              cmd_halt,
  input  logic              cmd_clear,
  input  logic [ADDR_W-1:0] pc,
  output logic              cpu_rst,
  output logic              cpu_en,
  output logic [ADDR_W:0]   prog_len,
  output logic [CNT_W-1:0]  cyc_cnt,
  output logic [2:0]        state,
  output logic              done,
  output logic              err
);

  localparam int LW = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept;
  logic              addr_max;
  logic              pc_end;
  logic              cnt_clr;

  assign accept   = ld_valid & ld_ready;
  assign addr_max = (addr_q == {ADDR_W{1'b1}});
  assign pc_end   = ({1'b0, pc} >= len_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    done_d  = done_q;
    err_d   = err_q;
    cnt_clr = 1'b0;
    if (cmd_clear) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      len_d   = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        // IDLE and LOAD differ only in that IDLE always starts at address 0
        ST_IDLE, ST_LOAD: begin
          if (accept) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_LOAD;
            if (ld_last || addr_max) begin
              len_d   = {1'b0, addr_q} + LW'(1);
              state_d = ST_HALT;
            end
            if (!ld_last && addr_max) begin
              err_d = 1'b1;
            end
          end
        end
        ST_HALT: begin
          if (!cmd_halt && !done_q) begin
            if (cmd_step) begin
              state_d = ST_STEP;
            end else if (cmd_run) begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (pc_end) begin
            done_d = 1'b1;
          end
          if (pc_end || cmd_halt) begin
            state_d = ST_HALT;
          end
        end
        ST_STEP: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Control outputs are decoded from the state register only (Moore)
  assign ld_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign cpu_rst  = ld_ready;
  assign cpu_en   = (state_q == ST_RUN) || (state_q == ST_STEP);

  assign imem_we    = accept;
  assign imem_addr  = addr_q;
  assign imem_wdata = ld_data;

  assign prog_len = len_q;
  assign state    = state_q;
  assign done     = done_q;
  assign err      = err_q;

  sat_counter #(
    .W(CNT_W)
  ) u_cyc_cnt (
    .clk  (clk),
    .reset(reset),
    .clr_i(cnt_clr),
    .en_i (cpu_en),
    .cnt_o(cyc_cnt)
  );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed testbench for cpu_run_ctrl: a default-width instance and a small
// instance (ADDR_W=3, CNT_W=2) for overflow and saturation corners.
module tb_cpu_run_ctrl;

  logic clk;
  logic resetN;

  logic       ldValidA, ldLastA, cmdRunA, cmdStepA, cmdHaltA, cmdClearA;
  logic [7:0] ldDataA, pcA;
  logic       ldReadyA, imemWeA, cpuRstA, cpuEnA, doneA, errA;
  logic [7:0] imemAddrA, imemWdataA;
  logic [8:0] progLenA;
  logic [15:0] cycCntA;
  logic [2:0] stateA;

  logic       ldValidB, ldLastB, cmdRunB, cmdStepB, cmdHaltB, cmdClearB;
  logic [7:0] ldDataB;
  logic [2:0] pcB;
  logic       ldReadyB, imemWeB, cpuRstB, cpuEnB, doneB, errB;
  logic [2:0] imemAddrB;
  logic [7:0] imemWdataB;
  logic [3:0] progLenB;
  logic [1:0] cycCntB;
  logic [2:0] stateB;

  int errors = 0;
  int checks = 0;

  logic [7:0] prog [0:5] = '{8'h84, 8'h0A, 8'h88, 8'h14, 8'h0D, 8'h28};

  cpu_run_ctrl #(.ADDR_W(8), .CNT_W(16)) dutA (
    .clk(clk), .reset(resetN),
    .ld_valid(ldValidA), .ld_ready(ldReadyA), .ld_data(ldDataA), .ld_last(ldLastA),
    .imem_we(imemWeA), .imem_addr(imemAddrA), .imem_wdata(imemWdataA),
    .cmd_run(cmdRunA), .cmd_step(cmdStepA), .cmd_halt(cmdHaltA), .cmd_clear(cmdClearA),
    .pc(pcA), .cpu_rst(cpuRstA), .cpu_en(cpuEnA), .prog_len(progLenA),
    .cyc_cnt(cycCntA), .state(stateA), .done(doneA), .err(errA)
  );

  cpu_run_ctrl #(.ADDR_W(3), .CNT_W(2)) dutB (
    .clk(clk), .reset(resetN),
    .ld_valid(ldValidB), .ld_ready(ldReadyB), .ld_data(ldDataB), .ld_last(ldLastB),
    .imem_we(imemWeB), .imem_addr(imemAddrB), .imem_wdata(imemWdataB),
    .cmd_run(cmdRunB), .cmd_step(cmdStepB), .cmd_halt(cmdHaltB), .cmd_clear(cmdClearB),
    .pc(pcB), .cpu_rst(cpuRstB), .cpu_en(cpuEnB), .prog_len(progLenB),
    .cyc_cnt(cycCntB), .state(stateB), .done(doneB), .err(errB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one edge, then drop every pulse input
  task automatic nextCycle();
    @(posedge clk);
    #1;
    ldValidA = 0; ldLastA = 0; cmdRunA = 0; cmdStepA = 0; cmdHaltA = 0; cmdClearA = 0;
    ldValidB = 0; ldLastB = 0; cmdRunB = 0; cmdStepB = 0; cmdHaltB = 0; cmdClearB = 0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    @(posedge clk);
    #1;
    resetN = 1'b1;
    checks++;
    if ({stateA, cpuRstA, cpuEnA, ldReadyA, imemWeA} !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got state=%0d rst=%b en=%b rdy=%b we=%b, expected 0 1 0 1 0",
               stateA, cpuRstA, cpuEnA, ldReadyA, imemWeA);
    end
    checks++;
    if ({progLenA, cycCntA, doneA, errA} !== {9'd0, 16'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_regs: got len=%0d cyc=%0d done=%b err=%b, expected 0 0 0 0",
               progLenA, cycCntA, doneA, errA);
    end
  endtask

  task automatic test_load();
    for (int i = 0; i < 6; i++) begin
      ldValidA = 1; ldDataA = prog[i]; ldLastA = (i == 5);
      #1;
      checks++;
      if ({imemWeA, imemAddrA, imemWdataA, cpuRstA} !== {1'b1, 8'(i), prog[i], 1'b1}) begin
        errors++;
        $display("[TB] FAIL load_write[%0d]: got we=%b addr=%0d data=%h rst=%b, expected 1 %0d %h 1",
                 i, imemWeA, imemAddrA, imemWdataA, cpuRstA, i, prog[i]);
      end
      nextCycle();
    end
    checks++;
    if ({progLenA, stateA, cpuRstA, cpuEnA, ldReadyA} !== {9'd6, 3'd2, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL load_done: got len=%0d state=%0d rst=%b en=%b rdy=%b, expected 6 2 0 0 0",
               progLenA, stateA, cpuRstA, cpuEnA, ldReadyA);
    end
    ldValidA = 1; ldDataA = 8'hFF;
    #1;
    checks++;
    if (imemWeA !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_in_halt: got we=%b, expected 0", imemWeA);
    end
    nextCycle();
  endtask

  task automatic test_run();
    logic [7:0] pcSeq [0:2] = '{8'd2, 8'd4, 8'd6};
    pcA = 8'd0;
    cmdRunA = 1;
    nextCycle();
    for (int k = 0; k < 3; k++) begin
      pcA = pcSeq[k];
      #1;
      checks++;
      if ({stateA, cpuEnA, doneA} !== {3'd3, 1'b1, 1'b0}) begin
        errors++;
        $display("[TB] FAIL run_cycle[%0d]: got state=%0d en=%b done=%b, expected 3 1 0",
                 k, stateA, cpuEnA, doneA);
      end
      nextCycle();
    end
    checks++;
    if ({stateA, cpuEnA, doneA, cycCntA} !== {3'd2, 1'b0, 1'b1, 16'd3}) begin
      errors++;
      $display("[TB] FAIL run_end: got state=%0d en=%b done=%b cyc=%0d, expected 2 0 1 3",
               stateA, cpuEnA, doneA, cycCntA);
    end
    pcA = 8'd0;
    cmdRunA = 1;
    nextCycle();
    checks++;
    if ({stateA, cpuEnA} !== {3'd2, 1'b0}) begin
      errors++;
      $display("[TB] FAIL run_while_done: got state=%0d en=%b, expected 2 0", stateA, cpuEnA);
    end
  endtask

  task automatic test_step();
    cmdClearA = 1;
    nextCycle();
    checks++;
    if ({stateA, progLenA, cycCntA, doneA, cpuRstA} !== {3'd0, 9'd0, 16'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL clear: got state=%0d len=%0d cyc=%0d done=%b rst=%b, expected 0 0 0 0 1",
               stateA, progLenA, cycCntA, doneA, cpuRstA);
    end
    for (int i = 0; i < 6; i++) begin
      ldValidA = 1; ldDataA = prog[i]; ldLastA = (i == 5);
      nextCycle();
    end
    pcA = 8'd0;
    for (int k = 0; k < 2; k++) begin
      cmdStepA = 1;
      nextCycle();
      checks++;
      if ({stateA, cpuEnA} !== {3'd4, 1'b1}) begin
        errors++;
        $display("[TB] FAIL step_on[%0d]: got state=%0d en=%b, expected 4 1", k, stateA, cpuEnA);
      end
      nextCycle();
      checks++;
      if ({stateA, cpuEnA} !== {3'd2, 1'b0}) begin
        errors++;
        $display("[TB] FAIL step_off[%0d]: got state=%0d en=%b, expected 2 0", k, stateA, cpuEnA);
      end
      nextCycle();
    end
    checks++;
    if (cycCntA !== 16'd2) begin
      errors++;
      $display("[TB] FAIL step_count: got cyc=%0d, expected 2", cycCntA);
    end
  endtask

  task automatic test_halt_priority();
    pcA = 8'd0;
    cmdRunA = 1;
    nextCycle();
    checks++;
    if ({stateA, cpuEnA} !== {3'd3, 1'b1}) begin
      errors++;
      $display("[TB] FAIL halt_pre_run: got state=%0d en=%b, expected 3 1", stateA, cpuEnA);
    end
    cmdHaltA = 1; cmdStepA = 1;
    nextCycle();
    checks++;
    if ({stateA, cpuEnA, doneA, cycCntA} !== {3'd2, 1'b0, 1'b0, 16'd3}) begin
      errors++;
      $display("[TB] FAIL halt_wins: got state=%0d en=%b done=%b cyc=%0d, expected 2 0 0 3",
               stateA, cpuEnA, doneA, cycCntA);
    end
    nextCycle();
    checks++;
    if ({stateA, cpuEnA, cycCntA} !== {3'd2, 1'b0, 16'd3}) begin
      errors++;
      $display("[TB] FAIL halt_no_step: got state=%0d en=%b cyc=%0d, expected 2 0 3",
               stateA, cpuEnA, cycCntA);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) begin
      ldValidB = 1; ldDataB = 8'h10 + 8'(i); ldLastB = 0;
      #1;
      checks++;
      if (i < 8) begin
        if ({imemWeB, imemAddrB, ldReadyB} !== {1'b1, 3'(i), 1'b1}) begin
          errors++;
          $display("[TB] FAIL ovf_write[%0d]: got we=%b addr=%0d rdy=%b, expected 1 %0d 1",
                   i, imemWeB, imemAddrB, ldReadyB, i);
        end
      end else begin
        if ({imemWeB, ldReadyB} !== {1'b0, 1'b0}) begin
          errors++;
          $display("[TB] FAIL ovf_ninth: got we=%b rdy=%b, expected 0 0", imemWeB, ldReadyB);
        end
      end
      nextCycle();
    end
    checks++;
    if ({errB, progLenB, stateB} !== {1'b1, 4'd8, 3'd2}) begin
      errors++;
      $display("[TB] FAIL ovf_final: got err=%b len=%0d state=%0d, expected 1 8 2",
               errB, progLenB, stateB);
    end
    pcB = 3'd0;
    cmdRunB = 1;
    nextCycle();
    for (int k = 0; k < 5; k++) begin
      nextCycle();
    end
    checks++;
    if ({stateB, cpuEnB, cycCntB, errB} !== {3'd3, 1'b1, 2'd3, 1'b1}) begin
      errors++;
      $display("[TB] FAIL cyc_saturate: got state=%0d en=%b cyc=%0d err=%b, expected 3 1 3 1",
               stateB, cpuEnB, cycCntB, errB);
    end
    cmdHaltB = 1;
    nextCycle();
    checks++;
    if ({stateB, cpuEnB, cycCntB} !== {3'd2, 1'b0, 2'd3}) begin
      errors++;
      $display("[TB] FAIL sat_halt: got state=%0d en=%b cyc=%0d, expected 2 0 3",
               stateB, cpuEnB, cycCntB);
    end
  endtask

  task automatic test_reset_midload();
    cmdClearA = 1;
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      ldValidA = 1; ldDataA = prog[i]; ldLastA = 0;
      nextCycle();
    end
    checks++;
    if ({stateA, imemAddrA} !== {3'd1, 8'd3}) begin
      errors++;
      $display("[TB] FAIL midload_pre: got state=%0d addr=%0d, expected 1 3", stateA, imemAddrA);
    end
    resetN = 1'b0;
    @(posedge clk);
    #1;
    resetN = 1'b1;
    checks++;
    if ({stateA, progLenA, cycCntA, ldReadyA, cpuRstA} !== {3'd0, 9'd0, 16'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL midload_reset: got state=%0d len=%0d cyc=%0d rdy=%b rst=%b, expected 0 0 0 1 1",
               stateA, progLenA, cycCntA, ldReadyA, cpuRstA);
    end
    ldValidA = 1; ldDataA = 8'h5A; ldLastA = 0;
    #1;
    checks++;
    if ({imemWeA, imemAddrA, imemWdataA} !== {1'b1, 8'd0, 8'h5A}) begin
      errors++;
      $display("[TB] FAIL midload_restart: got we=%b addr=%0d data=%h, expected 1 0 5a",
               imemWeA, imemAddrA, imemWdataA);
    end
    nextCycle();
    checks++;
    if ({stateA, imemAddrA} !== {3'd1, 8'd1}) begin
      errors++;
      $display("[TB] FAIL midload_next: got state=%0d addr=%0d, expected 1 1", stateA, imemAddrA);
    end
  endtask

  initial begin
    resetN = 1'b0;
    ldValidA = 0; ldLastA = 0; ldDataA = 0; cmdRunA = 0; cmdStepA = 0; cmdHaltA = 0; cmdClearA = 0; pcA = 0;
    ldValidB = 0; ldLastB = 0; ldDataB = 0; cmdRunB = 0; cmdStepB = 0; cmdHaltB = 0; cmdClearB = 0; pcB = 0;
    test_reset();
    test_load();
    test_run();
    test_step();
    test_halt_priority();
    test_overflow();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller for the single-cycle CPU. It streams a program byte-by-byte into instruction memory and holds the CPU in reset while loading. It then sequences execution: free run, single step, or halt. It gates the CPU through a clock-enable and stops automatically when the PC passes the end of the loaded program.

## Interface
- ADDR_W, 8, instruction-memory byte-address width
- CNT_W, 16, width of the executed-cycle counter

- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low (asserted at 0)
- ld_valid  input  1  loader byte valid
- ld_ready  output  1  controller accepts a loader byte
- ld_data  input  8  program byte
- ld_last  input  1  marks the final byte of the program
- imem_we  output  1  instruction-memory write enable
- imem_addr  output  ADDR_W  instruction-memory write byte address
- imem_wdata  output  8  instruction-memory write data
- cmd_run  input  1  one-cycle pulse: start free run
- cmd_step  input  1  one-cycle pulse: execute one instruction
- cmd_halt  input  1  one-cycle pulse: stop execution
- cmd_clear  input  1  one-cycle pulse: discard program and return to IDLE
- pc  input  ADDR_W  current CPU program counter (byte address)
- cpu_rst  output  1  active-high reset to the CPU
- cpu_en  output  1  CPU advance enable (gates PC update and register write)
- prog_len  output  ADDR_W+1  loaded program length in bytes
- cyc_cnt  output  CNT_W  number of cycles with cpu_en=1, saturating
- state  output  3  FSM state encoding
- done  output  1  sticky: program ran past its end
- err  output  1  sticky: load overflowed memory

## Operation
- States: IDLE=0, LOAD=1, HALT=2, RUN=3, STEP=4.
- Acceptance: a byte is accepted when ld_valid & ld_ready are both 1.
- imem_we = accept. imem_addr = load address counter. imem_wdata = ld_data. These are combinational, so the write lands on the same edge as acceptance.
- IDLE:
  - ld_ready=1, cpu_rst=1, cpu_en=0.
  - Accepting a byte writes address 0. The counter becomes 1.
  - If ld_last is also set: go to HALT with prog_len=1. Otherwise go to LOAD.
- LOAD:
  - ld_ready=1, cpu_rst=1.
  - Each accepted byte is written and the counter increments.
  - Accepting with ld_last: prog_len = counter+1, go to HALT.
  - Accepting at address 2^ADDR_W-1 without ld_last: treated as last, prog_len=2^ADDR_W, err=1.
- HALT:
  - ld_ready=0, cpu_rst=0, cpu_en=0.
  - cmd_run goes to RUN. cmd_step goes to STEP.
  - Both are ignored while done=1.
- RUN:
  - cpu_en=1 every cycle.
  - Goes to HALT on cmd_halt, or when pc >= prog_len. The end-of-program case also sets done=1.
- STEP: cpu_en=1 for exactly one cycle, then unconditionally back to HALT.
- cmd_clear in any state goes to IDLE and clears done, err, prog_len and cyc_cnt.
- Command priority: clear > halt > step > run.
- cyc_cnt increments on each cycle with cpu_en=1 and saturates at 2^CNT_W-1.
- Loader bytes presented outside IDLE/LOAD are not accepted (ld_ready=0).

## Timing
- reset=0 at an edge forces: state=IDLE, prog_len=0, cyc_cnt=0, done=0, err=0, counter=0. Resulting outputs: cpu_rst=1, cpu_en=0, ld_ready=1, imem_we=0.
- Reset mid-load abandons the load. The memory contents already written are left untouched.
- Registered (Moore, decoded from the state register): cpu_en, cpu_rst, ld_ready.
- Combinational: only imem_we, imem_addr, imem_wdata.
- Command latency: a command pulse sampled at edge N changes cpu_en from cycle N+1.
- RUN stop on halt: cmd_halt at edge N makes cpu_en=0 in cycle N+1, with no extra instruction.
- RUN stop on end of program: the pc >= prog_len check uses the registered pc, so end-of-program is detected in the cycle pc reaches prog_len. cpu_en drops the following cycle.
- cpu_rst falls on the cycle HALT is entered, and the CPU sees at least one reset cycle (LOAD ≥ 1 cycle) before that.
- Simultaneous cmd_halt and end of program: HALT with done=1.

## Structure
- Shared package cpu_ctrl_pkg holds:
  - the state enum and its encodings;
  - a localparam for the default ADDR_W, shared with instruction memory.
- Sub-module: sat_counter (parameterised width, enable, synchronous clear), used for cyc_cnt.
- Everything else is one FSM plus address and length registers.

## Test plan
- Load bytes 84 0A 88 14 0D 28 with ld_last on the 6th byte -> imem writes at addresses 0..5, prog_len=6, state=HALT, cpu_rst=0.
- After the load, pulse cmd_run while pc advances 0→2→4→6 -> cpu_en high for 3 cycles, then done=1, state=HALT, cyc_cnt=3.
- In HALT with pc=0, pulse cmd_step twice, 3 cycles apart -> cpu_en high for exactly 1 cycle each time, cyc_cnt=2, state back in HALT.
- In RUN, pulse cmd_halt and cmd_step in the same cycle -> halt wins, cpu_en=0 next cycle, no step executed.
- With ADDR_W=3, stream 9 bytes with no ld_last -> 8 writes (addresses 0..7), err=1, prog_len=8, state=HALT, 9th byte not accepted (ld_ready=0).
- Hold reset=0 for one edge during LOAD after 3 bytes -> state=IDLE, prog_len=0, counter=0, and the next accepted byte writes address 0.
